jk_excitation_driver: RTL and testbench
=======================================

# jk_excitation_driver

Drive side of the team's JK flip-flop interface. It accepts a stream of target state bits through a valid/ready handshake and buffers them in a small FIFO. For each bit it computes the J/K excitation from the flip-flop's current output, applies it for one clock, then checks that the flip-flop reached the target. It sits in front of the master-slave JK cell and replaces hand-written J/K stimulus, with a saturating mismatch counter for self-checking.

## Interface
- DEPTH, 4, target FIFO entries (power of two, ≥2)
- CNT_W, 8, width of mismatch counter
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- tgt_valid  input  1  upstream offers a target bit
- tgt_bit  input  1  desired next Q of the flip-flop
- tgt_ready  output  1  FIFO can accept; transfer when tgt_valid && tgt_ready
- q_fb  input  1  Q output of the driven JK flip-flop
- j  output  1  registered J drive
- k  output  1  registered K drive
- busy  output  1  FSM not in IDLE, or FIFO non-empty
- mismatch  output  1  one-cycle pulse: checked Q differed from target
- err_cnt  output  CNT_W  saturating count of mismatches

## Operation
- Reset (async, rst_n=0): FIFO emptied, FSM=IDLE, j=0, k=0, tgt_ready=1, busy=0, mismatch=0, err_cnt=0, internal target register=0.
- FIFO: push on tgt_valid && tgt_ready; tgt_ready = !full. No bypass: a bit pushed at edge N is poppable at edge N+1 at the earliest. When full, a push is refused even if a pop occurs in the same cycle. Pointers wrap modulo DEPTH; occupancy counter spans 0..DEPTH.
- FSM states: IDLE, DRIVE, CHECK.
  - IDLE: if FIFO non-empty, pop head into tgt_r and compute excitation from the current q_fb: q_fb=0 → j=tgt, k=0; q_fb=1 → j=0, k=!tgt. Register j/k and go to DRIVE. If the FIFO is empty, stay in IDLE with j=k=0.
  - DRIVE: j/k held for this one cycle. On exit, j=k=0 (hold), then go to CHECK.
  - CHECK: sample q_fb. If q_fb != tgt_r, pulse mismatch next cycle and increment err_cnt, saturating at 2^CNT_W−1. Go to IDLE.
- Don't-care excitation terms are always driven 0, so j=k=1 is never produced.
- A simultaneous push into an empty FIFO and FSM in IDLE: pop happens next cycle (no bypass).

## Timing
- Target popped at edge N. j/k valid from N to N+1 (exactly one cycle). j=k=0 from N+1. q_fb sampled at edge N+2. mismatch high from N+2 to N+3.
- Throughput: one target per 3 clocks. Back-to-back targets: next pop at edge N+3.
- j, k, tgt_ready, busy, mismatch, err_cnt are all registered outputs; no combinational input-to-output path.
- The flip-flop must settle Q within one cycle of the J/K edge. Q changing later than edge N+2 is reported as a mismatch.
- rst_n asserted mid-DRIVE: j/k drop to 0 immediately (async). Pending targets are lost. err_cnt is cleared.
- err_cnt at maximum: stays at maximum, and mismatch still pulses.

## Test plan
- Reset: rst_n=0 while j=1 is driven → j=k=0, err_cnt=0, tgt_ready=1 within the same cycle, without waiting for a clock edge.
- Sequence: with the JK cell attached, Q starts at 0. Push targets 1,1,0,0,1 → (j,k) pulses of (1,0),(0,0),(0,1),(0,0),(1,0), Q follows the targets, err_cnt=0, busy falls 3 clocks after the last pop.
- Backpressure: DEPTH=4, tgt_valid held high with FSM stalled → after 4 accepted bits tgt_ready=0. Next pop reasserts tgt_ready one cycle later. No bit is lost or duplicated.
- Mismatch: q_fb forced to 0, push target 1 → mismatch pulses once at pop+2, err_cnt=1. Repeat until err_cnt=255 (CNT_W=8), then push once more → err_cnt stays 255.
- Mid-operation reset: push 3 bits, assert rst_n during the DRIVE of bit 1 → FIFO empty, busy=0. After release, no j/k activity until a new push.
- Wrap-around: push and drain 10 alternating bits through DEPTH=4 → order preserved across pointer wrap, err_cnt=0.

Source files
------------

// File: rtl/jk_excitation_driver.sv
// Drive side of the JK flip-flop interface: buffers target bits, applies the J/K
// excitation for one clock, then confirms the flip-flop reached the target.
module jk_excitation_driver #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic             tgt_bit,
  output logic             tgt_ready,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           r_state;
  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             r_tgt_ready;
  logic             r_busy;
  logic             r_tgt;
  logic             r_j;
  logic             r_k;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_err_cnt;

  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_head;
  logic [OCC_W-1:0] w_count_nxt;

  // tgt_ready reflects the registered occupancy, so a full FIFO refuses a push
  // even when the engine pops in the same cycle.
  assign w_empty = (r_count == '0);
  assign w_push  = tgt_valid && r_tgt_ready;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    // NOTE: default assignment first so every path drives the signal; a path
    // that leaves it unassigned would infer a latch.
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + OCC_W'(1);
      2'b01:   w_count_nxt = r_count - OCC_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_tgt_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples
      // pre-edge values regardless of statement order.
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count     <= w_count_nxt;
      r_tgt_ready <= (w_count_nxt != FULL_CNT);
      r_busy      <= (r_state != S_IDLE) || !w_empty;
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by the pointers and count,
  // so stale entries are never read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tgt_bit;
  end

  // Excitation from the present Q; the don't-care term is always driven 0, so
  // J and K are never both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tgt      <= 1'b0;
      r_j        <= 1'b0;
      r_k        <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_mismatch <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_j <= 1'b0;
          r_k <= 1'b0;
          if (w_pop) begin
            r_tgt   <= w_head;
            r_j     <= !q_fb && w_head;
            r_k     <= q_fb && !w_head;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_j     <= 1'b0;
          r_k     <= 1'b0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (q_fb != r_tgt) begin
            r_mismatch <= 1'b1;
            if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
          end
          r_state <= S_IDLE;
        end
        default: begin
          r_j     <= 1'b0;
          r_k     <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign tgt_ready = r_tgt_ready;
  assign busy      = r_busy;
  assign j         = r_j;
  assign k         = r_k;
  assign mismatch  = r_mismatch;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: a behavioural JK cell as the plant, a
// timeline-based reference model checked every cycle, and directed scenarios.
module tb_jk_excitation_driver;

  localparam int DEPTH   = 4;
  localparam int CNT_W   = 8;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tgt_valid;
  logic             tgt_bit;
  logic             tgt_ready;
  logic             q_fb;
  logic             j;
  logic             k;
  logic             busy;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;

  jk_excitation_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_bit   (tgt_bit),
    .tgt_ready (tgt_ready),
    .q_fb      (q_fb),
    .j         (j),
    .k         (k),
    .busy      (busy),
    .mismatch  (mismatch),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  // Plant: JK flip-flop, not affected by the driver's reset.
  logic jk_q     = 1'b0;
  logic force_q0 = 1'b0;
  assign q_fb = force_q0 ? 1'b0 : jk_q;

  always @(posedge clk) begin
    case ({j, k})
      2'b10:   jk_q <= 1'b1;
      2'b01:   jk_q <= 1'b0;
      2'b11:   jk_q <= ~jk_q;
      default: jk_q <= jk_q;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: FIFO as a queue, engine as a timeline of pop edges.
  // Index {q, target}: 00 -> hold, 01 -> set, 10 -> reset, 11 -> hold.
  logic [1:0] excite [4] = '{2'b00, 2'b10, 2'b01, 2'b00};
  logic       m_q [$];
  int         cyc        = 0;
  int         m_last_pop = -100;
  int         m_chk_at   = -1;
  logic       m_chk_tgt  = 1'b0;
  logic       exp_j      = 1'b0;
  logic       exp_k      = 1'b0;
  logic       exp_ready  = 1'b1;
  logic       exp_busy   = 1'b0;
  logic       exp_mm     = 1'b0;
  int         exp_err    = 0;
  logic       pop_now    = 1'b0;
  logic       chk_now    = 1'b0;

  initial begin
    int   size_before;
    logic t;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_last_pop = -100;
        m_chk_at   = -1;
        exp_j      = 1'b0;
        exp_k      = 1'b0;
        exp_ready  = 1'b1;
        exp_busy   = 1'b0;
        exp_mm     = 1'b0;
        exp_err    = 0;
        pop_now    = 1'b0;
        chk_now    = 1'b0;
      end else begin
        cyc++;
        size_before = m_q.size();
        exp_mm  = 1'b0;
        chk_now = 1'b0;
        if (cyc == m_chk_at) begin
          chk_now = 1'b1;
          if (q_fb !== m_chk_tgt) begin
            exp_mm = 1'b1;
            if (exp_err < ERR_MAX) exp_err++;
          end
        end
        exp_j   = 1'b0;
        exp_k   = 1'b0;
        pop_now = 1'b0;
        if (size_before > 0 && cyc >= m_last_pop + 3) begin
          t = m_q.pop_front();
          {exp_j, exp_k} = excite[int'({q_fb, t})];
          m_last_pop = cyc;
          m_chk_at   = cyc + 2;
          m_chk_tgt  = t;
          pop_now    = 1'b1;
        end
        if (tgt_valid === 1'b1 && size_before < DEPTH) m_q.push_back(tgt_bit);
        exp_ready = (m_q.size() < DEPTH);
        exp_busy  = (size_before > 0) || (cyc > m_last_pop && cyc <= m_last_pop + 2);
      end
    end
  end

  // Per-cycle comparison on the falling edge, plus recording for scenario checks.
  logic [1:0] rec_jk [$];
  logic       rec_q  [$];
  int         mm_seen = 0;

  initial begin
    forever begin
      @(negedge clk);
      check("j",         32'(j),         32'(exp_j));
      check("k",         32'(k),         32'(exp_k));
      check("tgt_ready", 32'(tgt_ready), 32'(exp_ready));
      check("busy",      32'(busy),      32'(exp_busy));
      check("mismatch",  32'(mismatch),  32'(exp_mm));
      check("err_cnt",   32'(err_cnt),   32'(exp_err));
      if (pop_now) rec_jk.push_back({j, k});
      if (chk_now) rec_q.push_back(q_fb);
      if (mismatch === 1'b1) mm_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_bit(input logic b);
    int w;
    w = 0;
    tgt_valid = 1'b1;
    tgt_bit   = b;
    while (tgt_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w == 100) check("push_ready_timeout", 32'(tgt_ready), 32'd1);
    tick();
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(output int fall);
    fall = -1;
    tick();
    for (int w = 0; w < 300; w++) begin
      if (busy === 1'b0) begin
        fall = cyc;
        break;
      end
      tick();
    end
    if (fall < 0) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  logic       seq_bits   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [1:0] seq_jk_exp [5] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
  logic       bp_bits    [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int   fall;
    int   last_pop;
    int   acc;
    int   first_full;
    int   low_run;
    int   guard;
    int   w;
    int   mm_before;
    logic run_done;
    logic act;

    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",    32'(tgt_ready), 32'd1);
    check("rst_busy",     32'(busy),      32'd0);
    check("rst_j",        32'(j),         32'd0);
    check("rst_k",        32'(k),         32'd0);
    check("rst_mismatch", 32'(mismatch),  32'd0);
    check("rst_err",      32'(err_cnt),   32'd0);
    rst_n = 1'b1;
    tick();

    // Sequence 1,1,0,0,1 from Q=0.
    rec_jk.delete();
    rec_q.delete();
    for (int i = 0; i < 5; i++) push_bit(seq_bits[i]);
    wait_idle(fall);
    last_pop = m_last_pop;
    check("seq_busy_fall", 32'(fall - last_pop), 32'd3);
    check("seq_pops", 32'(rec_jk.size()), 32'd5);
    check("seq_checks", 32'(rec_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("seq_jk", 32'((i < rec_jk.size()) ? rec_jk[i] : 2'bxx), 32'(seq_jk_exp[i]));
      check("seq_q",  32'((i < rec_q.size()) ? rec_q[i] : 1'bx),    32'(seq_bits[i]));
    end
    check("seq_err", 32'(err_cnt), 32'd0);

    // Backpressure with valid held high from an idle, empty state.
    rec_q.delete();
    tgt_valid  = 1'b1;
    acc        = 0;
    first_full = -1;
    low_run    = 0;
    run_done   = 1'b0;
    guard      = 0;
    while (acc < 12 && guard < 200) begin
      tgt_bit = bp_bits[acc];
      if (tgt_ready === 1'b1) begin
        tick();
        acc++;
      end else begin
        tick();
      end
      if (tgt_ready === 1'b0) begin
        if (first_full < 0) first_full = acc;
        if (!run_done) low_run++;
      end else if (first_full >= 0) begin
        run_done = 1'b1;
      end
      guard++;
    end
    tgt_valid = 1'b0;
    wait_idle(fall);
    check("bp_accepted_all",    32'(acc),        32'd12);
    check("bp_full_after",      32'(first_full), 32'd6);
    check("bp_not_ready_cycles", 32'(low_run),   32'd2);
    check("bp_checks", 32'(rec_q.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check("bp_q_order", 32'((i < rec_q.size()) ? rec_q[i] : 1'bx), 32'(bp_bits[i]));

    // Wrap-around: 10 alternating bits.
    rec_q.delete();
    for (int i = 0; i < 10; i++) push_bit((i % 2) == 0);
    wait_idle(fall);
    check("wrap_checks", 32'(rec_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check("wrap_q_order", 32'((i < rec_q.size()) ? rec_q[i] : 1'bx), 32'((i % 2) == 0));
    check("wrap_err", 32'(err_cnt), 32'd0);

    // Mismatch with Q stuck at 0, up to and past saturation.
    force_q0 = 1'b1;
    mm_before = mm_seen;
    push_bit(1'b1);
    wait_idle(fall);
    check("mm_first_err",   32'(err_cnt), 32'd1);
    check("mm_first_pulse", 32'(mm_seen - mm_before), 32'd1);
    for (int i = 0; i < ERR_MAX - 1; i++) push_bit(1'b1);
    wait_idle(fall);
    check("mm_sat_err", 32'(err_cnt), 32'd255);
    mm_before = mm_seen;
    push_bit(1'b1);
    wait_idle(fall);
    check("mm_held_err",   32'(err_cnt), 32'd255);
    check("mm_held_pulse", 32'(mm_seen - mm_before), 32'd1);
    force_q0 = 1'b0;

    // Mid-operation reset during the DRIVE of the second bit (j=1 from Q=0).
    push_bit(1'b0);
    push_bit(1'b1);
    push_bit(1'b0);
    w = 0;
    while (j !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check("midop_j_driven", 32'(j), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midop_j",     32'(j),         32'd0);
    check("midop_k",     32'(k),         32'd0);
    check("midop_busy",  32'(busy),      32'd0);
    check("midop_ready", 32'(tgt_ready), 32'd1);
    check("midop_err",   32'(err_cnt),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      act = act | j | k;
    end
    check("midop_quiet_jk", 32'(act),  32'd0);
    check("midop_idle",     32'(busy), 32'd0);
    push_bit(1'b1);
    wait_idle(fall);
    check("midop_recover_err", 32'(err_cnt), 32'd0);
    check("midop_recover_q",   32'(q_fb),    32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
